// File: rtl/bp_mc_link_arbiter_pkg.sv
// Shared types for the two-requester BedRock-to-manycore link arbiter.
package bp_mc_link_arbiter_pkg;

  localparam int num_req_lp = 2;

  // Requester ID carried through the in-order tracking FIFO.
  typedef logic req_id_t;

  // Grant state: open arbitration, or held on a command stalled by the bridge.
  typedef enum logic {
    e_arb_open,
    e_arb_locked
  } arb_state_e;

endpackage

// File: rtl/bp_mc_link_arbiter_if.sv
// Requester-side and bridge-side handshakes of the link arbiter.
// Signal names are written from the arbiter's point of view.
interface bp_mc_link_arbiter_if #(
  parameter int msg_width_p = 128
);
  import bp_mc_link_arbiter_pkg::*;

  logic [num_req_lp-1:0][msg_width_p-1:0] cmd_i;
  logic [num_req_lp-1:0]                  cmd_v_i;
  logic [num_req_lp-1:0]                  cmd_ready_o;
  logic [num_req_lp-1:0][msg_width_p-1:0] resp_o;
  logic [num_req_lp-1:0]                  resp_v_o;
  logic [num_req_lp-1:0]                  resp_yumi_i;

  logic [msg_width_p-1:0]                 bridge_cmd_o;
  logic                                   bridge_cmd_v_o;
  logic                                   bridge_cmd_ready_i;
  logic [msg_width_p-1:0]                 bridge_resp_i;
  logic                                   bridge_resp_v_i;
  logic                                   bridge_resp_yumi_o;

  // Arbiter side.
  modport slave (
    input  cmd_i, cmd_v_i, resp_yumi_i, bridge_cmd_ready_i, bridge_resp_i, bridge_resp_v_i,
    output cmd_ready_o, resp_o, resp_v_o, bridge_cmd_o, bridge_cmd_v_o, bridge_resp_yumi_o
  );

  // Environment side: requesters plus bridge.
  modport master (
    output cmd_i, cmd_v_i, resp_yumi_i, bridge_cmd_ready_i, bridge_resp_i, bridge_resp_v_i,
    input  cmd_ready_o, resp_o, resp_v_o, bridge_cmd_o, bridge_cmd_v_o, bridge_resp_yumi_o
  );

endinterface

// File: rtl/bp_mc_link_id_fifo.sv
// In-order requester-ID FIFO. Occupancy is a registered counter; full is
// qualified by a same-cycle pop so a full FIFO can accept a push while popping.
module bp_mc_link_id_fifo
  import bp_mc_link_arbiter_pkg::*;
#(
  parameter  int depth_p      = 8,
  localparam int ptr_width_lp = $clog2(depth_p),
  localparam int cnt_width_lp = $clog2(depth_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    push_i,
  input  req_id_t                 id_i,
  input  logic                    pop_i,
  output req_id_t                 head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [cnt_width_lp-1:0] count_o
);

  logic [depth_p-1:0]      mem_q;
  logic [ptr_width_lp-1:0] wptr_q, rptr_q;
  logic [cnt_width_lp-1:0] count_q;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == cnt_width_lp'(depth_p)) & ~pop_i;
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally (depth is a power of two); push+pop leaves occupancy alone.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= id_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_i) rptr_q <= rptr_q + 1'b1;
      if (push_i & ~pop_i)      count_q <= count_q + 1'b1;
      else if (pop_i & ~push_i) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/bp_mc_link_arbiter.sv
// Shares one bridge io_cmd/io_resp port between two BedRock requesters.
// Commands are round-robin granted with zero-cycle latency; the ID of every
// accepted command is queued so in-order bridge responses return to their source.
module bp_mc_link_arbiter
  import bp_mc_link_arbiter_pkg::*;
#(
  parameter  int msg_width_p       = 128,
  parameter  int max_outstanding_p = 8,
  parameter  bit protocol_check_p  = 1'b1,
  localparam int cnt_width_lp      = $clog2(max_outstanding_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bp_mc_link_arbiter_if.slave     io,
  output logic [cnt_width_lp-1:0] outstanding_o
);

  arb_state_e              state_q, state_n;
  req_id_t                 rr_q, lock_id_q, winner, head;
  logic                    cmd_hs, pop, fifo_full, fifo_empty;
  logic [cnt_width_lp-1:0] count;

  // Winner: the locked requester while stalled, otherwise first valid from rr_q.
  always_comb begin
    winner = rr_q;
    if (state_q == e_arb_locked)                    winner = lock_id_q;
    else if (!io.cmd_v_i[rr_q] && io.cmd_v_i[~rr_q]) winner = ~rr_q;
  end

  // Command path: straight through to the bridge, blocked while the ID FIFO is full.
  always_comb begin
    io.cmd_ready_o    = '0;
    io.bridge_cmd_v_o = 1'b0;
    io.bridge_cmd_o   = '0;
    if (!reset_i) begin
      io.cmd_ready_o[winner] = io.bridge_cmd_ready_i & ~fifo_full;
      io.bridge_cmd_v_o      = io.cmd_v_i[winner] & ~fifo_full;
      io.bridge_cmd_o        = io.cmd_i[winner];
    end
  end

  assign cmd_hs = io.bridge_cmd_v_o & io.bridge_cmd_ready_i;

  // Response path: FIFO head picks the destination; nothing is offered when empty.
  always_comb begin
    io.resp_o             = '0;
    io.resp_v_o           = '0;
    io.bridge_resp_yumi_o = 1'b0;
    if (!reset_i) begin
      io.resp_o             = {num_req_lp{io.bridge_resp_i}};
      io.resp_v_o[head]     = io.bridge_resp_v_i & ~fifo_empty;
      io.bridge_resp_yumi_o = io.resp_yumi_i[head] & io.bridge_resp_v_i & ~fifo_empty;
    end
  end

  assign pop = io.bridge_resp_yumi_o;

  // Lock next-state: a presented but unaccepted command pins the grant.
  always_comb begin
    state_n = e_arb_open;
    if (io.bridge_cmd_v_o && !io.bridge_cmd_ready_i) state_n = e_arb_locked;
  end

  // Grant state, locked ID and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= e_arb_open;
      lock_id_q <= 1'b0;
      rr_q      <= 1'b0;
    end else begin
      state_q <= state_n;
      if (state_n == e_arb_locked) lock_id_q <= winner;
      if (cmd_hs)                  rr_q      <= ~winner;
    end
  end

  bp_mc_link_id_fifo #(
    .depth_p (max_outstanding_p)
  ) id_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (cmd_hs),
    .id_i    (winner),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign outstanding_o = reset_i ? '0 : count;

  if (protocol_check_p) begin : g_check
    // Flag responses with nothing in flight and consumes from a non-destination requester.
    always_ff @(posedge clk_i) begin
      if (!reset_i) begin
        assert (!(io.bridge_resp_v_i && fifo_empty))
          else $error("bridge response with no command in flight");
        assert (fifo_empty ? (io.resp_yumi_i == '0) : (io.resp_yumi_i[~head] == 1'b0))
          else $error("resp_yumi_i from a requester that is not the response destination");
      end
    end
  end

endmodule

// File: tb/tb_bp_mc_link_arbiter.sv
// Directed bench for bp_mc_link_arbiter: inputs change just after the falling
// edge and outputs are compared 1 time unit later, well away from the rising edge.
module tb_bp_mc_link_arbiter;
  import bp_mc_link_arbiter_pkg::*;

  localparam int W = 128;
  localparam int D = 8;
  localparam logic [W-1:0] M0 = 128'h1111;
  localparam logic [W-1:0] M1 = 128'h2222;

  logic       clk_i   = 1'b0;
  logic       reset_i = 1'b1;
  logic [3:0] outstanding_o;
  int         n_run   = 0;
  int         n_fail  = 0;

  bp_mc_link_arbiter_if #(.msg_width_p(W)) io();

  bp_mc_link_arbiter #(
    .msg_width_p       (W),
    .max_outstanding_p (D),
    .protocol_check_p  (1'b0)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .io            (io.slave),
    .outstanding_o (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic idle();
    io.cmd_v_i            = '0;
    io.bridge_cmd_ready_i = 1'b0;
    io.bridge_resp_v_i    = 1'b0;
    io.bridge_resp_i      = '0;
    io.resp_yumi_i        = '0;
  endtask

  // One command cycle with expected grant outputs.
  task automatic cmd_cycle(input logic [1:0] v, input logic rdy, input logic [1:0] exp_ready,
                           input logic exp_v, input logic [W-1:0] exp_msg, input string tag);
    io.cmd_v_i            = v;
    io.bridge_cmd_ready_i = rdy;
    #1;
    chk({tag, "_ready"}, io.cmd_ready_o, exp_ready);
    chk({tag, "_bv"}, io.bridge_cmd_v_o, exp_v);
    chk({tag, "_msg"}, io.bridge_cmd_o, exp_msg);
    tick();
  endtask

  // One response consumed by the expected destination.
  task automatic resp_one(input req_id_t h, input logic [W-1:0] data, input string tag);
    logic [1:0] oh;
    oh                 = h ? 2'b10 : 2'b01;
    io.bridge_resp_v_i = 1'b1;
    io.bridge_resp_i   = data;
    io.resp_yumi_i     = oh;
    #1;
    chk({tag, "_rv"}, io.resp_v_o, oh);
    chk({tag, "_yumi"}, io.bridge_resp_yumi_o, 1'b1);
    chk({tag, "_data"}, io.resp_o[h], data);
    tick();
    io.bridge_resp_v_i = 1'b0;
    io.resp_yumi_i     = '0;
  endtask

  initial begin
    io.cmd_i[0] = M0;
    io.cmd_i[1] = M1;
    idle();

    // Reset: every handshake output held low even with all inputs active.
    io.cmd_v_i            = 2'b11;
    io.bridge_cmd_ready_i = 1'b1;
    io.bridge_resp_v_i    = 1'b1;
    io.resp_yumi_i        = 2'b11;
    tick();
    #1;
    chk("rst_ready", io.cmd_ready_o, 2'b00);
    chk("rst_bv", io.bridge_cmd_v_o, 1'b0);
    chk("rst_rv", io.resp_v_o, 2'b00);
    chk("rst_yumi", io.bridge_resp_yumi_o, 1'b0);
    tick();
    reset_i = 1'b0;
    idle();
    #1;
    chk("rst_outst", outstanding_o, 4'd0);
    tick();

    // 1: both valid, bridge ready -> 0,1,0,1; responses routed in order.
    cmd_cycle(2'b11, 1'b1, 2'b01, 1'b1, M0, "t1_g0");
    cmd_cycle(2'b11, 1'b1, 2'b10, 1'b1, M1, "t1_g1");
    cmd_cycle(2'b11, 1'b1, 2'b01, 1'b1, M0, "t1_g2");
    cmd_cycle(2'b11, 1'b1, 2'b10, 1'b1, M1, "t1_g3");
    idle();
    #1;
    chk("t1_outst4", outstanding_o, 4'd4);
    tick();
    resp_one(1'b0, 128'hA5, "t1_r0");
    resp_one(1'b1, 128'hA5, "t1_r1");
    resp_one(1'b0, 128'hA5, "t1_r2");
    resp_one(1'b1, 128'hA5, "t1_r3");
    #1;
    chk("t1_outst0", outstanding_o, 4'd0);
    tick();

    // 2: move rr to requester 1, then stall requester 0; lock must hold it.
    cmd_cycle(2'b01, 1'b1, 2'b01, 1'b1, M0, "t2_pre");
    for (int i = 0; i < 5; i++)
      cmd_cycle((i >= 2) ? 2'b11 : 2'b01, 1'b0, 2'b00, 1'b1, M0, "t2_stall");
    cmd_cycle(2'b11, 1'b1, 2'b01, 1'b1, M0, "t2_hs0");
    cmd_cycle(2'b11, 1'b1, 2'b10, 1'b1, M1, "t2_hs1");
    idle();
    resp_one(1'b0, 128'h21, "t2_r0");
    resp_one(1'b0, 128'h22, "t2_r1");
    resp_one(1'b1, 128'h23, "t2_r2");

    // 3: fill to 8, then push and pop in the same cycle while full.
    for (int i = 0; i < D; i++)
      cmd_cycle(2'b01, 1'b1, 2'b01, 1'b1, M0, "t3_fill");
    #1;
    chk("t3_outst8", outstanding_o, 4'd8);
    chk("t3_full_ready", io.cmd_ready_o, 2'b00);
    chk("t3_full_bv", io.bridge_cmd_v_o, 1'b0);
    io.bridge_resp_v_i = 1'b1;
    io.bridge_resp_i   = 128'h31;
    io.resp_yumi_i     = 2'b01;
    #1;
    chk("t3_pp_yumi", io.bridge_resp_yumi_o, 1'b1);
    chk("t3_pp_ready", io.cmd_ready_o, 2'b01);
    chk("t3_pp_bv", io.bridge_cmd_v_o, 1'b1);
    tick();
    io.bridge_resp_v_i = 1'b0;
    io.resp_yumi_i     = '0;
    #1;
    chk("t3_pp_outst", outstanding_o, 4'd8);
    chk("t3_refull_ready", io.cmd_ready_o, 2'b00);
    tick();
    idle();
    for (int i = 0; i < D; i++)
      resp_one(1'b0, 128'h40 + W'(i), "t3_drain");
    #1;
    chk("t3_outst0", outstanding_o, 4'd0);
    tick();

    // 4: issue 1,0,0,1; requester 0 withholds yumi on R2.
    cmd_cycle(2'b10, 1'b1, 2'b10, 1'b1, M1, "t4_c0");
    cmd_cycle(2'b01, 1'b1, 2'b01, 1'b1, M0, "t4_c1");
    cmd_cycle(2'b01, 1'b1, 2'b01, 1'b1, M0, "t4_c2");
    cmd_cycle(2'b10, 1'b1, 2'b10, 1'b1, M1, "t4_c3");
    idle();
    resp_one(1'b1, 128'hB1, "t4_R1");
    for (int i = 0; i < 3; i++) begin
      io.bridge_resp_v_i = 1'b1;
      io.bridge_resp_i   = 128'hB2;
      io.resp_yumi_i     = 2'b00;
      #1;
      chk("t4_hold_rv", io.resp_v_o, 2'b01);
      chk("t4_hold_yumi", io.bridge_resp_yumi_o, 1'b0);
      chk("t4_hold_data", io.resp_o[0], 128'hB2);
      tick();
    end
    #1;
    chk("t4_hold_outst", outstanding_o, 4'd3);
    resp_one(1'b0, 128'hB2, "t4_R2");
    resp_one(1'b0, 128'hB3, "t4_R3");
    resp_one(1'b1, 128'hB4, "t4_R4");

    // 5: reset with 4 outstanding and a lock held on requester 1 (rr also on 1).
    for (int i = 0; i < 4; i++)
      cmd_cycle(2'b01, 1'b1, 2'b01, 1'b1, M0, "t5_fill");
    cmd_cycle(2'b10, 1'b0, 2'b00, 1'b1, M1, "t5_lock");
    #1;
    chk("t5_outst4", outstanding_o, 4'd4);
    tick();
    reset_i               = 1'b1;
    io.cmd_v_i            = 2'b11;
    io.bridge_cmd_ready_i = 1'b1;
    io.bridge_resp_v_i    = 1'b1;
    io.resp_yumi_i        = 2'b11;
    #1;
    chk("t5_rst_ready", io.cmd_ready_o, 2'b00);
    chk("t5_rst_bv", io.bridge_cmd_v_o, 1'b0);
    chk("t5_rst_rv", io.resp_v_o, 2'b00);
    chk("t5_rst_yumi", io.bridge_resp_yumi_o, 1'b0);
    tick();
    reset_i            = 1'b0;
    io.bridge_resp_v_i = 1'b0;
    io.resp_yumi_i     = '0;
    #1;
    chk("t5_post_outst", outstanding_o, 4'd0);
    chk("t5_post_rv", io.resp_v_o, 2'b00);
    chk("t5_post_ready", io.cmd_ready_o, 2'b01);
    chk("t5_post_msg", io.bridge_cmd_o, M0);
    tick();
    idle();
    #1;
    chk("t5_post_outst1", outstanding_o, 4'd1);
    resp_one(1'b0, 128'hC0, "t5_drain");

    // 6: bridge response with nothing in flight is never offered or consumed.
    io.bridge_resp_v_i = 1'b1;
    io.bridge_resp_i   = 128'hEE;
    io.resp_yumi_i     = 2'b11;
    #1;
    chk("t6_rv", io.resp_v_o, 2'b00);
    chk("t6_yumi", io.bridge_resp_yumi_o, 1'b0);
    tick();
    idle();
    #1;
    chk("t6_outst", outstanding_o, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
